// File: rtl/line_mem_arbiter.sv
// -----------------------------------------------------------------------------
// line_mem_arbiter
//
// Shares one 32-bit main-memory port between the instruction cache and the
// data cache. Each cache moves whole 256-bit lines, which go out as 8-beat
// bursts. When the data cache asks for both a dirty-victim writeback and a
// refill, the writeback burst runs first and the refill burst follows
// directly. If both caches are pending in IDLE, the port that was not served
// last wins. After reset, IC counts as served last, so the first tie goes to DC.
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   ic_read, ic_addr    icache refill request (level) and line address
//   ic_rdata, ic_done   icache refill line buffer, one-cycle completion pulse
//   dc_read, dc_addr    dcache refill request (level) and line address
//   dc_write            dcache victim writeback request (level)
//   dc_wb_addr          victim line address
//   dc_wdata            victim line data, beat n in bits [32n+31:32n]
//   dc_rdata, dc_done   dcache refill line buffer, one-cycle completion pulse
//   mem_req, mem_we     memory beat request and direction (1 = write)
//   mem_addr, mem_wdata memory beat address and write data
//   mem_rdata, mem_ack  memory read data and beat acknowledge
// -----------------------------------------------------------------------------
module line_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BEATS  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  // instruction cache
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [255:0]      ic_rdata,
  output logic              ic_done,
  // data cache
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [255:0]      dc_wdata,
  output logic [255:0]      dc_rdata,
  output logic              dc_done,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RF   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } gnt_t;

  state_t              state;
  gnt_t                grant;
  gnt_t                last_grant;
  logic [2:0]          beat;
  logic [255:0]        ic_buf;
  logic [255:0]        dc_buf;

  logic                ic_pend;
  logic                dc_pend;
  gnt_t                arb_gnt;
  logic                last_beat;
  logic [ADDR_W-6:0]   line_base;

  // The low five address bits select bytes within a line and play no part in
  // burst addressing; fold them into one sink so the intent stays visible.
  logic                unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ic_addr[4:0], dc_addr[4:0], dc_wb_addr[4:0]};

  assign ic_pend   = ic_read;
  assign dc_pend   = dc_read | dc_write;
  assign last_beat = (beat == 3'(BEATS - 1));

  // Refill line address of whichever port holds the grant.
  assign line_base = (grant == GNT_DC) ? dc_addr[ADDR_W-1:5] : ic_addr[ADDR_W-1:5];

  assign ic_rdata = ic_buf;
  assign dc_rdata = dc_buf;

  // Round-robin pick. Only meaningful in IDLE while something is pending.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the block leaves a value unassigned and infers a latch.
    arb_gnt = GNT_IC;
    if (ic_pend && dc_pend) begin
      arb_gnt = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
    end else if (dc_pend) begin
      arb_gnt = GNT_DC;
    end
  end

  // Memory-side beat signals decode directly from the registered state, so
  // they drop to zero the moment reset is asserted.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {dc_wb_addr[ADDR_W-1:5], beat, 2'b00};
        mem_wdata = dc_wdata[{beat, 5'b0} +: 32];
      end
      RF: begin
        mem_req  = 1'b1;
        mem_addr = {line_base, beat, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      grant      <= GNT_IC;
      last_grant <= GNT_IC;
      beat       <= '0;
      ic_done    <= 1'b0;
      dc_done    <= 1'b0;
      // NOTE: the line buffers are reset on purpose: they drive ic_rdata and
      // dc_rdata directly, and those outputs must read zero after reset.
      ic_buf     <= '0;
      dc_buf     <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values of the others, whatever the statement order.
      case (state)
        IDLE: begin
          if (ic_pend || dc_pend) begin
            grant <= arb_gnt;
            beat  <= '0;
            state <= (arb_gnt == GNT_DC && dc_write) ? WB : RF;
          end
        end

        WB: begin
          if (mem_ack) begin
            beat <= beat + 3'd1;
            if (last_beat) begin
              if (dc_read) begin
                state <= RF;
              end else begin
                state   <= DONE;
                dc_done <= 1'b1;
              end
            end
          end
        end

        RF: begin
          if (mem_ack) begin
            if (grant == GNT_DC) begin
              dc_buf[{beat, 5'b0} +: 32] <= mem_rdata;
            end else begin
              ic_buf[{beat, 5'b0} +: 32] <= mem_rdata;
            end
            beat <= beat + 3'd1;
            if (last_beat) begin
              state <= DONE;
              if (grant == GNT_DC) begin
                dc_done <= 1'b1;
              end else begin
                ic_done <= 1'b1;
              end
            end
          end
        end

        DONE: begin
          // The done pulse is high for exactly this state's single cycle.
          ic_done    <= 1'b0;
          dc_done    <= 1'b0;
          last_grant <= grant;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_line_mem_arbiter
//
// Self-checking bench for line_mem_arbiter. A stimulus table of single-port
// line transactions is applied in a loop. Hand-written sequences cover the
// round-robin tie, wait states on one beat and reset during a writeback.
// Expected memory beats are pushed to a scoreboard queue when a request is
// driven. A monitor pops and compares one entry for every acknowledged beat.
// -----------------------------------------------------------------------------
module tb_line_mem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        ic_rd;
    logic        dc_rd;
    logic        dc_wr;
    logic [31:0] ic_a;
    logic [31:0] dc_a;
    logic [31:0] wb_a;
    logic [31:0] rd_base;
    logic [31:0] wd_base;
    int          lat;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         ic_read;
  logic [31:0]  ic_addr;
  logic [255:0] ic_rdata;
  logic         ic_done;
  logic         dc_read;
  logic         dc_write;
  logic [31:0]  dc_addr;
  logic [31:0]  dc_wb_addr;
  logic [255:0] dc_wdata;
  logic [255:0] dc_rdata;
  logic         dc_done;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ack;

  logic [31:0]  rd_base;
  logic [255:0] exp_ic_line;
  logic [255:0] exp_dc_line;
  beat_t        beat_q[$];
  int           n_vec;
  int           n_err;
  int           ic_done_cnt;
  int           dc_done_cnt;

  line_mem_arbiter #(.ADDR_W(32), .BEATS(8)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ic_read    (ic_read),
    .ic_addr    (ic_addr),
    .ic_rdata   (ic_rdata),
    .ic_done    (ic_done),
    .dc_read    (dc_read),
    .dc_write   (dc_write),
    .dc_addr    (dc_addr),
    .dc_wb_addr (dc_wb_addr),
    .dc_wdata   (dc_wdata),
    .dc_rdata   (dc_rdata),
    .dc_done    (dc_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read beat n of a line returns rd_base + n.
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_req && !mem_we) mem_rdata = rd_base + {29'b0, mem_addr[4:2]};
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, well clear of the
  // rising edge at which the DUT samples them.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int n = 0; n < 8; n++) l[32*n +: 32] = base + 32'(n);
    return l;
  endfunction

  task automatic push_wb(input logic [31:0] a, input logic [31:0] wd_base);
    beat_t b;
    for (int n = 0; n < 8; n++) begin
      b.we    = 1'b1;
      b.addr  = {a[31:5], 3'(n), 2'b00};
      b.wdata = wd_base + 32'(n);
      beat_q.push_back(b);
    end
  endtask

  task automatic push_rf(input logic [31:0] a);
    beat_t b;
    for (int n = 0; n < 8; n++) begin
      b.we    = 1'b0;
      b.addr  = {a[31:5], 3'(n), 2'b00};
      b.wdata = 32'h0;
      beat_q.push_back(b);
    end
  endtask

  // Beat monitor and done counters, sampled 3 units after the falling edge
  // so that stimulus changes made at +1 have settled.
  always begin : monitor
    beat_t b;
    @(negedge clk);
    #3;
    if (rst_n && mem_req && mem_ack) begin
      check("beat_expected", 256'(beat_q.size() != 0), 256'd1);
      if (beat_q.size() != 0) begin
        b = beat_q.pop_front();
        check("beat_we", 256'(mem_we), 256'(b.we));
        check("beat_addr", 256'(mem_addr), 256'(b.addr));
        if (b.we) check("beat_wdata", 256'(mem_wdata), 256'(b.wdata));
      end
    end
    if (ic_done) ic_done_cnt++;
    if (dc_done) dc_done_cnt++;
  end

  task automatic do_reset();
    step();
    rst_n    = 1'b0;
    ic_read  = 1'b0;
    dc_read  = 1'b0;
    dc_write = 1'b0;
    mem_ack  = 1'b1;
    repeat (2) step();
    beat_q.delete();
    exp_ic_line = '0;
    exp_dc_line = '0;
    rst_n = 1'b1;
  endtask

  // Drive one single-port transaction and check its completion.
  task automatic run_vec(input vec_t v);
    int         cyc;
    logic       got;
    logic [1:0] exp_port;
    step();
    ic_addr    = v.ic_a;
    dc_addr    = v.dc_a;
    dc_wb_addr = v.wb_a;
    dc_wdata   = mk_line(v.wd_base);
    rd_base    = v.rd_base;
    ic_read    = v.ic_rd;
    dc_read    = v.dc_rd;
    dc_write   = v.dc_wr;
    if (v.dc_wr) push_wb(v.wb_a, v.wd_base);
    if (v.ic_rd) push_rf(v.ic_a);
    else if (v.dc_rd) push_rf(v.dc_a);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      step();
      cyc++;
      got = ic_done | dc_done;
    end
    check("done_latency", 256'(cyc), 256'(v.lat));
    exp_port = v.ic_rd ? 2'b10 : 2'b01;
    check("done_port", 256'({ic_done, dc_done}), 256'(exp_port));
    if (v.ic_rd) exp_ic_line = mk_line(v.rd_base);
    else if (v.dc_rd) exp_dc_line = mk_line(v.rd_base);
    check("ic_rdata", ic_rdata, exp_ic_line);
    check("dc_rdata", dc_rdata, exp_dc_line);
    ic_read  = 1'b0;
    dc_read  = 1'b0;
    dc_write = 1'b0;
    step();
    check("done_one_cycle", 256'({ic_done, dc_done}), 256'd0);
    check("beats_left", 256'(beat_q.size()), 256'd0);
  endtask

  // Withholds the acknowledge of beat 4 for three rising edges.
  task automatic stall_beat4(input logic [31:0] line_a);
    logic [31:0] exp_a;
    int          n;
    exp_a = {line_a[31:5], 3'd4, 2'b00};
    n = 0;
    while (!(mem_req && mem_addr[4:2] == 3'd4) && n < 50) begin
      step();
      n++;
    end
    check("stall_found_beat4", 256'(n < 50), 256'd1);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr_hold", 256'(mem_addr), 256'(exp_a));
      check("stall_we_hold", 256'({mem_req, mem_we}), 256'(2'b10));
    end
    mem_ack = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    vec_t       vecs[5];
    vec_t       vw;
    vec_t       vr;
    logic [1:0] exp_order[4];
    int         cyc;
    logic       got;
    int         dcnt0;
    int         n;

    n_vec       = 0;
    n_err       = 0;
    ic_done_cnt = 0;
    dc_done_cnt = 0;
    // NOTE: the bench drives DUT inputs with blocking assignments from
    // procedural code, away from the sampling edge, so no ordering race exists.
    rst_n       = 1'b0;
    ic_read     = 1'b0;
    dc_read     = 1'b0;
    dc_write    = 1'b0;
    ic_addr     = '0;
    dc_addr     = '0;
    dc_wb_addr  = '0;
    dc_wdata    = '0;
    mem_ack     = 1'b1;
    rd_base     = '0;
    exp_ic_line = '0;
    exp_dc_line = '0;

    // Reset state: every output reads zero.
    repeat (2) step();
    check("rst_mem_req", 256'(mem_req), 256'd0);
    check("rst_mem_we", 256'(mem_we), 256'd0);
    check("rst_mem_addr", 256'(mem_addr), 256'd0);
    check("rst_mem_wdata", 256'(mem_wdata), 256'd0);
    check("rst_ic_done", 256'(ic_done), 256'd0);
    check("rst_dc_done", 256'(dc_done), 256'd0);
    check("rst_ic_rdata", ic_rdata, 256'd0);
    check("rst_dc_rdata", dc_rdata, 256'd0);
    rst_n = 1'b1;

    // Round-robin tie from reset: DC, IC, DC, IC. Each port drops its
    // request on done and re-raises it one cycle later.
    exp_order[0] = 2'b01;
    exp_order[1] = 2'b10;
    exp_order[2] = 2'b01;
    exp_order[3] = 2'b10;
    step();
    ic_addr = 32'h0000_4000;
    dc_addr = 32'h0000_5000;
    rd_base = 32'h0000_0600;
    ic_read = 1'b1;
    dc_read = 1'b1;
    push_rf(32'h0000_5000);
    push_rf(32'h0000_4000);
    push_rf(32'h0000_5000);
    push_rf(32'h0000_4000);
    cyc = 0;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      n = 0;
      while (!got && n < 100) begin
        step();
        cyc++;
        n++;
        got = ic_done | dc_done;
      end
      check("tie_grant_order", 256'({ic_done, dc_done}), 256'(exp_order[t]));
      check("tie_interval", 256'(cyc), (t == 0) ? 256'd9 : 256'd10);
      if (dc_done) begin
        dc_read = 1'b0;
        check("tie_dc_rdata", dc_rdata, mk_line(32'h600));
      end
      if (ic_done) begin
        ic_read = 1'b0;
        check("tie_ic_rdata", ic_rdata, mk_line(32'h600));
      end
      cyc = 0;
      step();
      cyc++;
      if (t == 0) dc_read = 1'b1;
      if (t == 1) ic_read = 1'b1;
    end
    check("tie_done_counts", 256'({ic_done_cnt[7:0], dc_done_cnt[7:0]}), 256'(16'h0202));
    check("tie_beats_left", 256'(beat_q.size()), 256'd0);

    do_reset();

    // Single-port transaction table.
    //           ic_rd dc_rd dc_wr ic_a          dc_a          wb_a          rd_base  wd_base  lat
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,        32'h0,        32'h100, 32'h0,   9};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_2000, 32'h8000_0040, 32'h200, 32'hA0,  17};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h8000_0100, 32'h0,   32'hB0,  9};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_3FFF, 32'h0,        32'h300, 32'h0,   9};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFE4, 32'h0,        32'h0,        32'h400, 32'h0,   9};
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Refill with three wait states on beat 4: done arrives three cycles late.
    vw = '{1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h0, 32'h0, 32'h700, 32'h0, 12};
    fork
      run_vec(vw);
      stall_beat4(32'h0000_7000);
    join

    // Reset asserted during a writeback at beat 5.
    step();
    dc_wb_addr = 32'h8000_0040;
    dc_wdata   = mk_line(32'hC0);
    dc_write   = 1'b1;
    push_wb(32'h8000_0040, 32'hC0);
    n = 0;
    while (!(mem_req && mem_we && mem_addr[4:2] == 3'd5) && n < 50) begin
      step();
      n++;
    end
    check("wb_found_beat5", 256'(n < 50), 256'd1);
    dcnt0 = dc_done_cnt;
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", 256'(mem_req), 256'd0);
    check("arst_mem_we", 256'(mem_we), 256'd0);
    check("arst_mem_addr", 256'(mem_addr), 256'd0);
    check("arst_mem_wdata", 256'(mem_wdata), 256'd0);
    check("arst_dc_rdata", dc_rdata, 256'd0);
    beat_q.delete();
    dc_write = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    exp_ic_line = '0;
    exp_dc_line = '0;
    repeat (12) step();
    check("arst_no_done", 256'(dc_done_cnt - dcnt0), 256'd0);
    // Reissued writeback starts again from beat 0.
    vr = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0040, 32'h0, 32'hC0, 9};
    run_vec(vr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Shares a single 32-bit word-wide main-memory port between the instruction cache and the data cache. Each cache requests whole 256-bit lines; the arbiter sequences them as 8-beat bursts. A dirty-victim writeback runs before its refill when the data cache asks for both. Sits between the two L1 caches and the memory interface, with round-robin arbitration between the caches.

## Interface
- ADDR_W, 32, byte-address width
- BEATS, 8, 32-bit beats per line (line = 256 bits, 32 bytes; fixed)

- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- ic_read  in  1  icache line refill request, level, held until ic_done
- ic_addr  in  ADDR_W  icache refill address; bits [4:0] ignored
- ic_rdata  out  256  refilled line; beat n in bits [32n+31:32n]
- ic_done  out  1  one-cycle completion pulse
- dc_read  in  1  dcache line refill request, level, held until dc_done
- dc_write  in  1  dcache victim writeback request, level, held until dc_done
- dc_addr  in  ADDR_W  dcache refill address; bits [4:0] ignored
- dc_wb_addr  in  ADDR_W  victim line address; bits [4:0] ignored
- dc_wdata  in  256  victim line; beat n in bits [32n+31:32n]
- dc_rdata  out  256  refilled line; beat n in bits [32n+31:32n]
- dc_done  out  1  one-cycle completion pulse
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = write beat, 0 = read beat
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  32  write beat data
- mem_rdata  in  32  read beat data; valid when mem_ack = 1
- mem_ack  in  1  beat accepted/completed; ignored while mem_req = 0

## Operation
- States: IDLE, WB, RF, DONE.
- Registers:
  - grant: 0 = IC, 1 = DC.
  - last_grant: reset value IC.
  - 3-bit beat counter.
  - Two 256-bit line buffers, one per port.
- Transaction contents:
  - Granted DC: writeback first (if dc_write), then refill (if dc_read).
  - Granted IC: refill only.
- IDLE arbitration:
  - Pending IC = ic_read.
  - Pending DC = dc_read | dc_write.
  - Only one port pending: grant it.
  - Both pending: grant the port that is not last_grant. After reset, the first tie goes to DC.
- IDLE to next state:
  - DC granted with dc_write: go to WB.
  - Otherwise: go to RF.
  - beat is cleared to 0.
- WB state:
  - mem_req=1, mem_we=1.
  - mem_addr = {dc_wb_addr[31:5], beat, 2'b00}.
  - mem_wdata = dc_wdata[32*beat +: 32].
  - On mem_ack: beat+1.
  - On ack of beat 7: go to RF if dc_read, else DONE; beat wraps to 0.
- RF state:
  - mem_req=1, mem_we=0.
  - mem_addr = {line_addr[31:5], beat, 2'b00}, where line_addr is the granted port's refill address.
  - On mem_ack: mem_rdata is written into the granted port's buffer slot [beat]; beat+1.
  - On ack of beat 7: go to DONE.
- DONE state:
  - Pulse the granted port's done for 1 cycle.
  - last_grant <= grant.
  - Go to IDLE.
- rdata outputs:
  - ic_rdata/dc_rdata are driven straight from their buffers.
  - Valid from the done cycle.
  - Held until that port's next refill beat overwrites them.
  - Writeback-only transactions leave dc_rdata unchanged.
- Outputs outside WB/RF: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Requesters keep addr/wdata stable from request until done.
- The arbiter never re-samples an address mid-burst except through the held inputs.
- A request dropped mid-transaction is a protocol violation. The burst still completes and done still pulses.
- A request held into the cycle after done is seen as a new request. Requesters must deassert on done.

## Timing
- Reset (asynchronous, RST_N=0):
  - state=IDLE, beat=0, last_grant=IC, buffers=0.
  - All outputs 0.
  - Any in-flight burst is abandoned, with no done pulse. Requesters must reissue.
- Release: first arbitration on the first rising edge with RST_N=1.
- Zero-wait memory (mem_ack tied 1), request seen at IDLE edge E0:
  - Refill only: beats in cycles E0..E8; DONE after E8; done high E8–E9; IDLE at E9.
  - Writeback + refill: 16 beats; done high E16–E17.
  - Writeback only: done high E8–E9.
- Wait states: each cycle with mem_req=1, mem_ack=0 stretches the burst by 1 cycle.
- Throughput: minimum 1 IDLE cycle between transactions. Back-to-back refills complete every 10 cycles.
- Tie between requests arriving at a DONE edge: decided in the following IDLE cycle, using the just-updated last_grant.

## Test plan
- Reset, ic_read=1 alone, ic_addr=0x0000_1234, mem_rdata=0x100+beat, ack every cycle:
  - mem_addr sequences 0x1220..0x123C, mem_we=0.
  - ic_done pulses once, 9 cycles after the request edge.
  - ic_rdata beat n = 0x100+n.
- dc_write=dc_read=1, dc_wb_addr=0x8000_0040, dc_addr=0x0000_2000, dc_wdata beat n = 0xA0+n:
  - 8 write beats to 0x8000_0040..0x8000_005C with data 0xA0..0xA7.
  - Then 8 reads from 0x2000..0x201C.
  - One dc_done.
- ic_read and dc_read both high from reset, each reasserted on its done:
  - Grant order DC, IC, DC, IC.
  - No port starves.
- Refill with mem_ack low for 3 cycles on beat 4:
  - mem_addr and mem_we hold.
  - done is delayed exactly 3 cycles.
  - Data in the buffer is correct.
- RST_N low mid-WB at beat 5:
  - Outputs 0 immediately (asynchronous).
  - No done pulse.
  - Reissued request restarts at beat 0.
- dc_write=1 alone:
  - Writeback only; dc_done after 8 beats.
  - dc_rdata unchanged.
